simon_round_engine: RTL
=======================

SIMON_ROUND_ENGINE -- requirements
Module: simon_round_engine

Interface
REQ-001 Parameter CHANNELS, default 16: number of LEDs and guess choices; SHALL be a power of two, 2..16.
REQ-002 Parameter MAX_ROUNDS, default 8: sequence length that wins the game; range 1..32.
REQ-003 Parameter ON_TICKS, default 2: ticks each sequence element is lit; minimum 1.
REQ-004 Parameter OFF_TICKS, default 1: dark ticks between elements; minimum 1.
REQ-005 Parameter TIMEOUT_TICKS, default 10: ticks allowed per guess before loss; minimum 1.
REQ-006 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; SHALL be nonzero.
REQ-007 Derived widths: IDX_W = clog2(CHANNELS); RND_W = clog2(MAX_ROUNDS+1).
REQ-008 clk  in  1  system clock; all logic on its rising edge.
REQ-009 reset  in  1  synchronous, active-low reset.
REQ-010 tick  in  1  one-clk timing strobe from clock_divider.
REQ-011 start  in  1  one-clk pulse that begins a game.
REQ-012 guess_valid  in  1  one-clk pulse qualifying guess_idx.
REQ-013 guess_idx  in  IDX_W  player's chosen channel.
REQ-014 leds  out  CHANNELS  LED drive.
REQ-015 round  out  RND_W  current sequence length.
REQ-016 best_round  out  RND_W  highest number of rounds completed since reset.
REQ-017 state  out  3  IDLE=0, SHOW_ON=1, SHOW_OFF=2, INPUT=3, WIN=4, LOSE=5.
REQ-018 guess_ok  out  1  one-clk pulse on each correct guess.
REQ-019 game_over  out  1  high while in LOSE; game_won  out  1  high while in WIN.

Function
REQ-020 A 16-bit Fibonacci LFSR with taps 16,14,13,11 SHALL advance every clk in every state.
REQ-021 An element SHALL be captured as lfsr[IDX_W-1:0] into sequence slot round-1 on the clk it is appended.
REQ-022 start in IDLE, WIN or LOSE: append slot 0, set round=1 and pos=0, enter SHOW_ON on the next clk; start is ignored in SHOW_ON, SHOW_OFF and INPUT.
REQ-023 SHOW_ON: leds = one-hot(seq[pos]); after ON_TICKS ticks, enter SHOW_OFF.
REQ-024 SHOW_OFF: leds=0; after OFF_TICKS ticks, enter INPUT with pos=0 if pos==round-1; otherwise increment pos and enter SHOW_ON.
REQ-025 The tick counter SHALL clear on every state change.
REQ-026 INPUT: leds=0; guess_valid is ignored in every other state.
REQ-027 Correct guess (guess_idx==seq[pos]): pulse guess_ok on the next clk and clear the timeout counter.
REQ-028 After a correct guess, if pos<round-1, increment pos.
REQ-029 After a correct guess at pos==round-1: enter WIN if round==MAX_ROUNDS; otherwise increment round, append the new slot, set pos=0 and enter SHOW_ON.
REQ-030 Wrong guess: enter LOSE; guess_ok stays 0.
REQ-031 Timeout: in INPUT, TIMEOUT_TICKS ticks with no guess_valid -> LOSE.
REQ-032 If guess_valid and tick coincide, the guess is processed and that tick is not counted.
REQ-033 On entry to WIN, best_round SHALL be set to MAX_ROUNDS.
REQ-034 On entry to LOSE, best_round SHALL be set to max(best_round, round-1); best_round persists across games.
REQ-035 WIN: leds all ones.
REQ-036 LOSE: leds SHALL toggle between all ones and all zeros on each tick, starting at all ones.
REQ-037 All outputs SHALL be registered; a state transition occurs one clk after the qualifying input.

Reset
REQ-038 While reset=0 at a clk edge, the block SHALL set state=IDLE, leds=0, round=0, best_round=0, guess_ok=0, game_over=0, game_won=0, pos=0, counters=0 and lfsr=LFSR_SEED.
REQ-039 Reset asserted mid-game SHALL abandon the game and clear best_round.
REQ-040 Sequence memory contents are don't-care after reset.

Verification
Benches use CHANNELS=4, MAX_ROUNDS=2, ON_TICKS=1, OFF_TICKS=1, TIMEOUT_TICKS=4.
REQ-041 Reset, then start pulse -> next clk: state=1, round=1, leds one-hot of LFSR_SEED[1:0] as captured at the start clk.
REQ-042 Show seq[0], then correct guess -> guess_ok pulse; round=2; element 0 then element 1 shown; correct guesses for both -> state=4, leds=4'b1111, best_round=2.
REQ-043 In round 2, wrong guess at pos 0 -> state=5, game_over=1, best_round=1; leds toggle 1111/0000 on each tick.
REQ-044 INPUT with no guess for 4 ticks -> LOSE on the clk after the 4th tick; a guess coinciding with the 4th tick is processed and no timeout occurs.
REQ-045 start during SHOW_ON and guess_valid during SHOW_OFF -> no effect on state, round or pos.
REQ-046 reset=0 held for one clk while in INPUT -> all outputs return to reset values; a following start replays from seed.

Source files
------------

// File: rtl/simon_round_engine_if.sv
// simon_round_engine_if
// Purpose: bundles the game-engine handshake and status signals so the engine
//          and its driver share one port.
// Signals:
//   tick        one-clk timing strobe (from the clock divider)
//   start       one-clk pulse that begins a game
//   guess_valid one-clk pulse qualifying guess_idx
//   guess_idx   player's chosen channel
//   leds        LED drive
//   round       current sequence length
//   best_round  highest number of rounds completed since reset
//   state       engine state code
//   guess_ok    one-clk pulse on each correct guess
//   game_over   high while in LOSE
//   game_won    high while in WIN
// Modports: master drives the inputs of the engine, slave is the engine side.
interface simon_round_engine_if #(
    parameter int CHANNELS   = 16,
    parameter int MAX_ROUNDS = 8
);
    localparam int IDX_W = $clog2(CHANNELS);
    localparam int RND_W = $clog2(MAX_ROUNDS + 1);

    logic                tick;
    logic                start;
    logic                guess_valid;
    logic [IDX_W-1:0]    guess_idx;
    logic [CHANNELS-1:0] leds;
    logic [RND_W-1:0]    round;
    logic [RND_W-1:0]    best_round;
    logic [2:0]          state;
    logic                guess_ok;
    logic                game_over;
    logic                game_won;

    modport master (
        output tick, start, guess_valid, guess_idx,
        input  leds, round, best_round, state, guess_ok, game_over, game_won
    );

    modport slave (
        input  tick, start, guess_valid, guess_idx,
        output leds, round, best_round, state, guess_ok, game_over, game_won
    );
endinterface

// File: rtl/simon_round_engine.sv
// simon_round_engine
// Purpose: memory-game engine. Grows a random LED sequence one element per
//          round, plays it back on tick timing, then checks the player's
//          guesses with a per-guess timeout. Tracks the best completed round.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   bus    simon_round_engine_if.slave (tick/start/guess in; leds/status out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start after reset
// SHOW_ON  | lighting sequence element seq[pos] for ON_TICKS ticks
// SHOW_OFF | dark gap of OFF_TICKS ticks between elements
// INPUT    | waiting for the player's guess for seq[pos], with timeout
// WIN      | whole MAX_ROUNDS sequence repeated; all LEDs lit
// LOSE     | wrong guess or timeout; LEDs blink on tick
module simon_round_engine #(
    parameter int          CHANNELS      = 16,
    parameter int          MAX_ROUNDS    = 8,
    parameter int          ON_TICKS      = 2,
    parameter int          OFF_TICKS     = 1,
    parameter int          TIMEOUT_TICKS = 10,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic                 clk,
    input logic                 reset,
    simon_round_engine_if.slave bus
);
    localparam int IDX_W = $clog2(CHANNELS);
    localparam int RND_W = $clog2(MAX_ROUNDS + 1);
    localparam int SEQ_N = 1 << RND_W;
    localparam int T_A   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int T_MAX = (T_A > TIMEOUT_TICKS) ? T_A : TIMEOUT_TICKS;
    localparam int CNT_W = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHOW_ON  = 3'd1,
        S_SHOW_OFF = 3'd2,
        S_INPUT    = 3'd3,
        S_WIN      = 3'd4,
        S_LOSE     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [RND_W-1:0]    pos_q, pos_d;
    logic [RND_W-1:0]    round_q, round_d;
    logic [RND_W-1:0]    best_q, best_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] leds_q, leds_d;
    logic                ok_q, ok_d;
    logic                over_q, won_q;
    logic [15:0]         lfsr_q;
    logic                lfsr_fb;

    // Sized to the full index range of pos/round so every read is in range.
    logic [IDX_W-1:0]    seq [SEQ_N];
    logic                app_en;
    logic [RND_W-1:0]    app_slot;

    logic [RND_W-1:0]    round_m1;
    logic [RND_W-1:0]    pos_inc;
    logic                last_pos;

    function automatic logic [CHANNELS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [CHANNELS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign round_m1 = round_q - RND_W'(1);
    assign pos_inc  = pos_q + RND_W'(1);
    assign last_pos = (pos_q == round_m1);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        round_d  = round_q;
        best_d   = best_q;
        cnt_d    = cnt_q;
        leds_d   = leds_q;
        ok_d     = 1'b0;
        app_en   = 1'b0;
        app_slot = '0;

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (bus.start) begin
                    state_d  = S_SHOW_ON;
                    round_d  = RND_W'(1);
                    pos_d    = '0;
                    cnt_d    = '0;
                    app_en   = 1'b1;
                    app_slot = '0;
                    // slot 0 is being written this clk, so bypass the memory
                    leds_d   = onehot(lfsr_q[IDX_W-1:0]);
                end else if (state_q == S_LOSE && bus.tick) begin
                    leds_d = ~leds_q;
                end
            end

            S_SHOW_ON: begin
                if (bus.tick) begin
                    if (cnt_q == CNT_W'(ON_TICKS - 1)) begin
                        state_d = S_SHOW_OFF;
                        cnt_d   = '0;
                        leds_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_SHOW_OFF: begin
                if (bus.tick) begin
                    if (cnt_q == CNT_W'(OFF_TICKS - 1)) begin
                        cnt_d = '0;
                        if (last_pos) begin
                            state_d = S_INPUT;
                            pos_d   = '0;
                        end else begin
                            state_d = S_SHOW_ON;
                            pos_d   = pos_inc;
                            leds_d  = onehot(seq[pos_inc]);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_INPUT: begin
                // A guess takes priority over a coincident tick.
                if (bus.guess_valid) begin
                    cnt_d = '0;
                    if (bus.guess_idx == seq[pos_q]) begin
                        ok_d = 1'b1;
                        if (!last_pos) begin
                            pos_d = pos_inc;
                        end else if (round_q == RND_W'(MAX_ROUNDS)) begin
                            state_d = S_WIN;
                            leds_d  = '1;
                            best_d  = RND_W'(MAX_ROUNDS);
                        end else begin
                            state_d  = S_SHOW_ON;
                            round_d  = round_q + RND_W'(1);
                            pos_d    = '0;
                            app_en   = 1'b1;
                            app_slot = round_q;
                            leds_d   = onehot(seq[0]);
                        end
                    end else begin
                        state_d = S_LOSE;
                        leds_d  = '1;
                        best_d  = (round_m1 > best_q) ? round_m1 : best_q;
                    end
                end else if (bus.tick) begin
                    if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                        state_d = S_LOSE;
                        cnt_d   = '0;
                        leds_d  = '1;
                        best_d  = (round_m1 > best_q) ? round_m1 : best_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                leds_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            round_q <= '0;
            best_q  <= '0;
            cnt_q   <= '0;
            leds_q  <= '0;
            ok_q    <= 1'b0;
            over_q  <= 1'b0;
            won_q   <= 1'b0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            round_q <= round_d;
            best_q  <= best_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            ok_q    <= ok_d;
            over_q  <= (state_d == S_LOSE);
            won_q   <= (state_d == S_WIN);
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    // Sequence memory carries no reset; stale contents are never shown.
    always_ff @(posedge clk) begin
        if (reset && app_en) begin
            seq[app_slot] <= lfsr_q[IDX_W-1:0];
        end
    end

    assign bus.leds       = leds_q;
    assign bus.round      = round_q;
    assign bus.best_round = best_q;
    assign bus.state      = state_q;
    assign bus.guess_ok   = ok_q;
    assign bus.game_over  = over_q;
    assign bus.game_won   = won_q;
endmodule
